mult_share_arbiter: RTL and testbench

//  Sequencer/arbiter that time-shares one combinational array multiplier
//  (multiplierNx) between NREQ requesters. It accepts operand pairs through a

---
 rtl/mult_share_arbiter_pkg.sv | 25 ++
 rtl/mult_share_arbiter_rr_grant.sv | 35 +++
 rtl/multiplierNx.sv | 23 ++
 rtl/mult_share_arbiter.sv | 149 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the time-shared multiplier arbiter:
// FSM encodings and the id-width helper.
package mult_share_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Bits needed to index n requesters; never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_grant.sv
// Round-robin one-hot picker: first asserted request at or above i_ptr,
// wrapping; no grant at all while i_en is low.
module rr_grant #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic           i_en,
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_id
);

  logic           w_found;
  logic [IDW-1:0] w_idx;

  // Scan upward from the pointer and stop at the first requester.
  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IDW'((int'(i_ptr) + k) % N);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/multiplierNx.sv
// Unsigned W x W combinational array multiplier built from shifted
// partial products; the full 2*W-bit product is returned.
module multiplierNx #(
  parameter int W = 4
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  logic [2*W-1:0] w_acc;

  // Sum of partial products, one row per bit of i_b.
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < W; k++) begin
      w_acc = w_acc + ((2*W)'(i_a & {W{i_b[k]}}) << k);
    end
  end

  assign o_p = w_acc;

endmodule

// File: rtl/mult_share_arbiter.sv
// Time-shares one combinational multiplier between NREQ requesters:
// round-robin accept, multicycle settle, tagged response with backpressure.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int  W      = 4,
  parameter int  NREQ   = 2,
  parameter int  SETTLE = 1,
  localparam int IDW    = clog2_min1(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*W-1:0]    rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [7:0]        ops_done
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_cnt;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_rr_ptr;
  logic           r_rsp_valid;
  logic [2*W-1:0] r_rsp_data;
  logic [IDW-1:0] r_rsp_id;
  logic           r_busy;
  logic [7:0]     r_ops_done;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_id;
  logic            w_xfer;
  logic            w_rsp_fire;
  logic [W-1:0]    w_a_sel;
  logic [W-1:0]    w_b_sel;
  logic [2*W-1:0]  w_prod;

  rr_grant #(.N(NREQ), .IDW(IDW)) u_rr_grant (
    .i_en  (r_state == S_IDLE),
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_id  (w_gnt_id)
  );

  // The array sees only the operand registers, so the inputs may change
  // freely once a request has been accepted.
  multiplierNx #(.W(W)) u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  assign w_xfer     = |(req_valid & w_gnt);
  assign w_rsp_fire = r_rsp_valid & rsp_ready;
  assign w_a_sel    = req_a[int'(w_gnt_id)*W +: W];
  assign w_b_sel    = req_b[int'(w_gnt_id)*W +: W];

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) w_state_nxt = S_CALC;
        else        w_state_nxt = S_IDLE;
      end
      S_CALC: begin
        if (r_cnt == 4'd1) w_state_nxt = S_HOLD;
        else               w_state_nxt = S_CALC;
      end
      S_HOLD: begin
        if (w_rsp_fire) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Operand capture, settle countdown, response registers and op counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 4'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_ops_done  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_a      <= w_a_sel;
            r_b      <= w_b_sel;
            r_id     <= w_gnt_id;
            r_rr_ptr <= IDW'((int'(w_gnt_id) + 1) % NREQ);
            r_cnt    <= 4'(SETTLE);
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rsp_data  <= w_prod;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + 8'd1;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_busy;
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed, table-driven bench for mult_share_arbiter (W=4, NREQ=2) with a
// second SETTLE=3 instance for the reset-during-calculation case.
module tb_mult_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_ready;
  logic [7:0] req_a, req_b;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       busy;
  logic [7:0] ops_done;

  logic [1:0] req_valid3, req_ready3;
  logic [7:0] req_a3, req_b3;
  logic       rsp_valid3, rsp_ready3;
  logic [7:0] rsp_data3;
  logic       rsp_id3;
  logic       busy3;
  logic [7:0] ops_done3;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_ops;

  typedef struct {
    int         id;
    logic [3:0] a, b, a2, b2;
    logic [7:0] exp;
    int         stall;
  } vec_t;
  vec_t tbl [8];

  mult_share_arbiter #(.W(4), .NREQ(2), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .ops_done(ops_done)
  );

  mult_share_arbiter #(.W(4), .NREQ(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_data(rsp_data3), .rsp_id(rsp_id3), .busy(busy3), .ops_done(ops_done3)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req_valid  = 2'b00; rsp_ready  = 1'b0;
    req_valid3 = 2'b00; rsp_ready3 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_ops_done",  32'(ops_done),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 8'd0;
  endtask

  // One transaction on lane id; a2/b2 replace the operands right after accept.
  task automatic txn(input int id, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] a2, input logic [3:0] b2,
                     input logic [7:0] exp, input int stall);
    int         k;
    logic [7:0] held_d;
    logic       held_id;
    @(negedge clk);
    req_a[id*4 +: 4] = a;
    req_b[id*4 +: 4] = b;
    req_valid[id]    = 1'b1;
    rsp_ready        = 1'b0;
    #1;
    k = 0;
    while (!req_ready[id] && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("grant_onehot", 32'(req_ready), 32'(1 << id));
    @(posedge clk); #1;
    req_valid[id]    = 1'b0;
    req_a[id*4 +: 4] = a2;
    req_b[id*4 +: 4] = b2;
    chk("busy_calc", 32'(busy), 32'd1);
    k = 1;
    @(negedge clk);
    while (!rsp_valid && k < 40) begin
      @(negedge clk); k++;
    end
    chk("latency", 32'(k), 32'd2);
    chk("rsp_data", 32'(rsp_data), 32'(exp));
    chk("rsp_id", 32'(rsp_id), 32'(id));
    held_d  = rsp_data;
    held_id = rsp_id;
    for (int s = 0; s < stall; s++) begin
      req_valid = 2'b11;
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'(held_d));
      chk("stall_id", 32'(rsp_id), 32'(held_id));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_ops = exp_ops + 8'd1;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("ops_done", 32'(ops_done), 32'(exp_ops));
    chk("busy_idle", 32'(busy), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int         k;
    logic       prev_id;
    int         exp_id [3];
    logic [7:0] exp_d  [3];

    tbl[0] = '{0, 4'd15, 4'd15, 4'd15, 4'd15, 8'd225, 0};
    tbl[1] = '{1, 4'd3,  4'd5,  4'd3,  4'd5,  8'd15,  0};
    tbl[2] = '{0, 4'd7,  4'd9,  4'd7,  4'd9,  8'd63,  5};
    tbl[3] = '{1, 4'd0,  4'd13, 4'd0,  4'd13, 8'd0,   1};
    tbl[4] = '{0, 4'd2,  4'd2,  4'd9,  4'd9,  8'd4,   0};
    tbl[5] = '{1, 4'd12, 4'd10, 4'd12, 4'd10, 8'd120, 2};
    tbl[6] = '{0, 4'd8,  4'd8,  4'd8,  4'd8,  8'd64,  0};
    tbl[7] = '{1, 4'd15, 4'd1,  4'd15, 4'd1,  8'd15,  0};

    req_a = 8'd0; req_b = 8'd0; req_a3 = 8'd0; req_b3 = 8'd0;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].a2, tbl[i].b2, tbl[i].exp, tbl[i].stall);
    end

    // Both lanes valid continuously: grants must alternate 0,1,0.
    do_reset();
    exp_id = '{0, 1, 0};
    exp_d  = '{8'd15, 8'd63, 8'd15};
    @(negedge clk);
    req_a = {4'd7, 4'd3};
    req_b = {4'd9, 4'd5};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    chk("rr_first_grant", 32'(req_ready), 32'd1);
    prev_id = 1'b1;
    for (int n = 0; n < 3; n++) begin
      k = 0;
      @(negedge clk);
      while (!rsp_valid && k < 20) begin
        @(negedge clk); k++;
      end
      chk("rr_rsp_id", 32'(rsp_id), 32'(exp_id[n]));
      chk("rr_rsp_data", 32'(rsp_data), 32'(exp_d[n]));
      chk("rr_no_repeat", 32'(rsp_id != prev_id), 32'd1);
      prev_id = rsp_id;
      @(posedge clk); #1;
      if (n == 2) begin
        req_valid = 2'b00;
        rsp_ready = 1'b0;
      end
    end
    chk("rr_ops_done", 32'(ops_done), 32'd3);

    // Exhaustive products through lane 1 with random response stalls.
    do_reset();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        txn(1, 4'(a), 4'(b), 4'(a), 4'(b), 8'(a * b), int'($urandom_range(0, 2)));
      end
    end
    chk("ops_wrap", 32'(ops_done), 32'd0);

    // SETTLE=3 instance: reset in the middle of the settle window.
    do_reset();
    @(negedge clk);
    req_a3 = {4'd0, 4'd5};
    req_b3 = {4'd0, 4'd5};
    req_valid3 = 2'b01;
    #1;
    chk("s3_grant", 32'(req_ready3), 32'd1);
    @(posedge clk); #1;
    req_valid3 = 2'b00;
    @(posedge clk); #1;
    chk("s3_busy_mid", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s3_rst_busy", 32'(busy3), 32'd0);
    chk("s3_rst_valid", 32'(rsp_valid3), 32'd0);
    chk("s3_rst_data", 32'(rsp_data3), 32'd0);
    chk("s3_rst_id", 32'(rsp_id3), 32'd0);
    chk("s3_rst_ops", 32'(ops_done3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid3) k++;
    end
    chk("s3_no_orphan_rsp", 32'(k), 32'd0);
    req_valid3 = 2'b11;
    #1;
    chk("s3_rr_ptr_reset", 32'(req_ready3), 32'd1);
    req_valid3 = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
